// File: rtl/mem_pkg.sv
// mem_pkg: shared types and helpers for the MEM stage.
// Access size decode, byte-enable generation and load extension live here
// so the stage and its lane-steering block agree on one definition.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  typedef struct packed {
    logic [31:0] alures;
    logic [31:0] memres;
    logic [31:0] mulres;
    logic [31:0] divres;
    logic        memread;
    logic        mul_ready;
    logic        div_ready;
    logic        regwrite;
    logic [4:0]  rd;
  } wb_t;

  // Unlisted encodings (011/110/111) fall back to a full word access.
  function automatic size_t mem_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: mem_size = SZ_B;
      F3_H, F3_HU: mem_size = SZ_H;
      F3_W:        mem_size = SZ_W;
      default:     mem_size = SZ_W;
    endcase
  endfunction

  function automatic logic [3:0] be_gen(input logic [2:0] f3, input logic [1:0] a);
    case (mem_size(f3))
      SZ_B:    be_gen = 4'b0001 << a;
      SZ_H:    be_gen = a[1] ? 4'b1100 : 4'b0011;
      default: be_gen = 4'b1111;
    endcase
  endfunction

  // Byte lane by a[1:0], half lane by a[1]; bit 2 of funct3 selects zero-extension.
  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{a, 3'b000} +: 8];
    h = a[1] ? rdata[31:16] : rdata[15:0];
    case (mem_size(f3))
      SZ_B:    load_ext = {{24{b[7] & ~f3[2]}}, b};
      SZ_H:    load_ext = {{16{h[15] & ~f3[2]}}, h};
      default: load_ext = rdata;
    endcase
  endfunction

endpackage

// File: rtl/load_store_align.sv
// load_store_align: purely combinational lane steering for the MEM stage.
// Produces store byte enables and lane-replicated write data, and the
// aligned, extended load result.
module load_store_align (
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] storedata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o
);
  import mem_pkg::*;

  // Replicate the store operand into every lane it may land in.
  always_comb begin
    be_o    = be_gen(funct3_i, addr_lo_i);
    ldata_o = load_ext(funct3_i, addr_lo_i, rdata_i);
    case (mem_size(funct3_i))
      SZ_B:    wdata_o = {4{storedata_i[7:0]}};
      SZ_H:    wdata_o = {2{storedata_i[15:0]}};
      default: wdata_o = storedata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline MEM stage with req/ack data-memory handshake.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (trap misaligned half/word
// accesses instead of serving them aligned).
module mem_access_stage #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        dbg,
  input  logic [31:0] EX_MEM_alures,
  input  logic [31:0] EX_MEM_storedata,
  input  logic [2:0]  EX_MEM_funct3,
  input  logic        EX_MEM_memread,
  input  logic        EX_MEM_memwrite,
  input  logic [4:0]  EX_MEM_rd,
  input  logic        EX_MEM_regwrite,
  input  logic        EX_MEM_mul_ready,
  input  logic        EX_MEM_div_ready,
  input  logic [31:0] EX_MEM_mulres,
  input  logic [31:0] EX_MEM_divres,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mem_hold,
  output logic        mem_err,
  output logic        mem_misalign,
  output logic [31:0] MEM_WB_alures,
  output logic [31:0] MEM_WB_memres,
  output logic [31:0] MEM_WB_mulres,
  output logic [31:0] MEM_WB_divres,
  output logic        MEM_WB_memread,
  output logic        MEM_WB_mul_ready,
  output logic        MEM_WB_div_ready,
  output logic        MEM_WB_regwrite,
  output logic [4:0]  MEM_WB_rd
);
  import mem_pkg::*;

  localparam logic [7:0] TIMEOUT_CNT = 8'(ACK_TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rbuf_q, rbuf_d;
  wb_t         wb_q, wb_d;
  logic        mem_err_q;
  logic        acc, mis, start, timeout, wb_en;
  logic [31:0] rd_src, ldata;

  assign acc   = EX_MEM_memread | EX_MEM_memwrite;
  assign start = acc & ~dbg & ~mis & ~Rst;

  // A parked access in DONE extends from the buffered word, not the live bus.
  assign rd_src    = (state_q == DONE) ? rbuf_q : dmem_rdata;
  assign dmem_we   = EX_MEM_memwrite;
  assign dmem_addr = {EX_MEM_alures[31:2], 2'b00};

  load_store_align u_align (
    .funct3_i    (EX_MEM_funct3),
    .addr_lo_i   (EX_MEM_alures[1:0]),
    .storedata_i (EX_MEM_storedata),
    .rdata_i     (rd_src),
    .be_o        (dmem_be),
    .wdata_o     (dmem_wdata),
    .ldata_o     (ldata)
  );

`ifdef MEM_MISALIGN_TRAP_EN
  size_t sz;
  logic  mis_q;
  assign sz  = mem_size(EX_MEM_funct3);
  assign mis = acc & (((sz == SZ_H) & EX_MEM_alures[0]) |
                      ((sz == SZ_W) & (EX_MEM_alures[1:0] != 2'b00)));
  assign mem_misalign = mis_q;

  // One pulse when the trapped instruction retires into MEM/WB.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) mis_q <= 1'b0;
    else     mis_q <= wb_en & mis;
  end
`else
  assign mis          = 1'b0;
  assign mem_misalign = 1'b0;
`endif

  // Access FSM: request generation, wait counting, debug parking of read data.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rbuf_d   = rbuf_q;
    dmem_req = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          dmem_req = 1'b1;
          if (!dmem_ack) begin
            state_d = WAIT;
            cnt_d   = 8'd1;
          end
        end
      end
      WAIT: begin
        dmem_req = ~Rst;
        cnt_d    = cnt_q + 8'd1;
        if (dmem_ack) begin
          if (dbg) begin
            rbuf_d  = dmem_rdata;
            state_d = DONE;
          end else begin
            state_d = IDLE;
          end
        end else if (cnt_q == TIMEOUT_CNT) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      DONE: begin
        if (!dbg) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The abandon cycle and the DONE release cycle retire the instruction, so
  // neither stalls upstream; otherwise the same access would be re-issued.
  assign mem_hold = (dmem_req & ~dmem_ack & ~timeout) | ((state_q == DONE) & dbg);
  assign wb_en    = (~dbg & ~mem_hold) | timeout;

  // MEM/WB next state: load on retire, hold otherwise.
  always_comb begin
    wb_d = wb_q;
    if (wb_en) begin
      wb_d.alures    = EX_MEM_alures;
      wb_d.memres    = ldata;
      wb_d.mulres    = EX_MEM_mulres;
      wb_d.divres    = EX_MEM_divres;
      wb_d.memread   = EX_MEM_memread & ~EX_MEM_memwrite;
      wb_d.mul_ready = EX_MEM_mul_ready;
      wb_d.div_ready = EX_MEM_div_ready;
      wb_d.regwrite  = EX_MEM_regwrite & ~timeout & ~mis;
      wb_d.rd        = EX_MEM_rd;
    end
  end

  // State, counter, read buffer, MEM/WB and error pulse registers.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      rbuf_q    <= 32'd0;
      wb_q      <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rbuf_q    <= rbuf_d;
      wb_q      <= wb_d;
      mem_err_q <= timeout;
    end
  end

  assign mem_err          = mem_err_q;
  assign MEM_WB_alures    = wb_q.alures;
  assign MEM_WB_memres    = wb_q.memres;
  assign MEM_WB_mulres    = wb_q.mulres;
  assign MEM_WB_divres    = wb_q.divres;
  assign MEM_WB_memread   = wb_q.memread;
  assign MEM_WB_mul_ready = wb_q.mul_ready;
  assign MEM_WB_div_ready = wb_q.div_ready;
  assign MEM_WB_regwrite  = wb_q.regwrite;
  assign MEM_WB_rd        = wb_q.rd;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed bench for mem_access_stage with a MEM/WB scoreboard.
// Honours MEM_MISALIGN_TRAP_EN for the misaligned-access step.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        Rst, dbg;
  logic [31:0] EX_MEM_alures, EX_MEM_storedata, EX_MEM_mulres, EX_MEM_divres;
  logic [2:0]  EX_MEM_funct3;
  logic        EX_MEM_memread, EX_MEM_memwrite, EX_MEM_regwrite;
  logic        EX_MEM_mul_ready, EX_MEM_div_ready;
  logic [4:0]  EX_MEM_rd;
  logic        dmem_req, dmem_we, dmem_ack, mem_hold, mem_err, mem_misalign;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic [31:0] MEM_WB_alures, MEM_WB_memres, MEM_WB_mulres, MEM_WB_divres;
  logic        MEM_WB_memread, MEM_WB_mul_ready, MEM_WB_div_ready, MEM_WB_regwrite;
  logic [4:0]  MEM_WB_rd;

  always #5 clk = ~clk;

  mem_access_stage #(.ACK_TIMEOUT(4)) dut (
    .clk(clk), .Rst(Rst), .dbg(dbg),
    .EX_MEM_alures(EX_MEM_alures), .EX_MEM_storedata(EX_MEM_storedata),
    .EX_MEM_funct3(EX_MEM_funct3), .EX_MEM_memread(EX_MEM_memread),
    .EX_MEM_memwrite(EX_MEM_memwrite), .EX_MEM_rd(EX_MEM_rd),
    .EX_MEM_regwrite(EX_MEM_regwrite), .EX_MEM_mul_ready(EX_MEM_mul_ready),
    .EX_MEM_div_ready(EX_MEM_div_ready), .EX_MEM_mulres(EX_MEM_mulres),
    .EX_MEM_divres(EX_MEM_divres),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .mem_hold(mem_hold), .mem_err(mem_err),
    .mem_misalign(mem_misalign),
    .MEM_WB_alures(MEM_WB_alures), .MEM_WB_memres(MEM_WB_memres),
    .MEM_WB_mulres(MEM_WB_mulres), .MEM_WB_divres(MEM_WB_divres),
    .MEM_WB_memread(MEM_WB_memread), .MEM_WB_mul_ready(MEM_WB_mul_ready),
    .MEM_WB_div_ready(MEM_WB_div_ready), .MEM_WB_regwrite(MEM_WB_regwrite),
    .MEM_WB_rd(MEM_WB_rd)
  );

  typedef struct {
    logic [31:0] alures;
    logic [31:0] memres;
    logic        memread;
    logic        regwrite;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wb(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      $error("FAIL %s: scoreboard empty, observed rd %0d", tag, MEM_WB_rd);
    end else begin
      e = sb.pop_front();
      chk({tag, "_alures"}, MEM_WB_alures, e.alures);
      chk({tag, "_memres"}, MEM_WB_memres, e.memres);
      chk({tag, "_memread"}, 32'(MEM_WB_memread), 32'(e.memread));
      chk({tag, "_regwrite"}, 32'(MEM_WB_regwrite), 32'(e.regwrite));
      chk({tag, "_rd"}, 32'(MEM_WB_rd), 32'(e.rd));
    end
  endtask

  task automatic set_ex(input logic [31:0] a, input logic [31:0] sd, input logic [2:0] f3,
                        input logic mr, input logic mw, input logic [4:0] rd, input logic rw);
    EX_MEM_alures    = a;
    EX_MEM_storedata = sd;
    EX_MEM_funct3    = f3;
    EX_MEM_memread   = mr;
    EX_MEM_memwrite  = mw;
    EX_MEM_rd        = rd;
    EX_MEM_regwrite  = rw;
    EX_MEM_mul_ready = 1'b0;
    EX_MEM_div_ready = 1'b0;
    EX_MEM_mulres    = 32'd0;
    EX_MEM_divres    = 32'd0;
  endtask

  task automatic idle_ex();
    EX_MEM_memread  = 1'b0;
    EX_MEM_memwrite = 1'b0;
    EX_MEM_regwrite = 1'b0;
    dmem_ack        = 1'b0;
  endtask

  // Zero-wait load: ack in the request cycle.
  task automatic zload(input string tag, input logic [31:0] a, input logic [2:0] f3,
                       input logic [31:0] rdata, input logic [31:0] expv, input logic [4:0] rd);
    set_ex(a, 32'd0, f3, 1'b1, 1'b0, rd, 1'b1);
    dmem_rdata = rdata;
    dmem_ack   = 1'b1;
    sb.push_back('{a, expv, 1'b1, 1'b1, rd});
    @(negedge clk);
    chk({tag, "_req"}, 32'(dmem_req), 32'd1);
    chk({tag, "_hold"}, 32'(mem_hold), 32'd0);
    tick();
    check_wb(tag);
    idle_ex();
  endtask

  // Zero-wait store: check the bus image.
  task automatic zstore(input string tag, input logic [31:0] a, input logic [31:0] sd,
                        input logic [2:0] f3, input logic [3:0] be, input logic [31:0] wd,
                        input logic [31:0] addr, input logic [4:0] rd);
    set_ex(a, sd, f3, 1'b0, 1'b1, rd, 1'b0);
    dmem_rdata = 32'd0;
    dmem_ack   = 1'b1;
    sb.push_back('{a, 32'd0, 1'b0, 1'b0, rd});
    @(negedge clk);
    chk({tag, "_we"}, 32'(dmem_we), 32'd1);
    chk({tag, "_be"}, 32'(dmem_be), 32'(be));
    chk({tag, "_wdata"}, dmem_wdata, wd);
    chk({tag, "_addr"}, dmem_addr, addr);
    tick();
    check_wb(tag);
    idle_ex();
  endtask

  initial begin
    int holdcnt;
    Rst = 1'b1;
    dbg = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = 32'd0;
    set_ex(32'd0, 32'd0, 3'b000, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    tick();
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_hold", 32'(mem_hold), 32'd0);
    chk("rst_err", 32'(mem_err), 32'd0);
    chk("rst_regwrite", 32'(MEM_WB_regwrite), 32'd0);
    chk("rst_memres", MEM_WB_memres, 32'd0);
    Rst = 1'b0;
    tick();

    zload("lb_103", 32'h103, 3'b000, 32'h8000_0000, 32'hFFFF_FF80, 5'd5);
    zstore("sh_202", 32'h202, 32'h1234_ABCD, 3'b001, 4'b1100, 32'hABCD_ABCD, 32'h200, 5'd1);
    zstore("sb_003", 32'h003, 32'h0000_00A5, 3'b000, 4'b1000, 32'hA5A5_A5A5, 32'h000, 5'd2);
    zstore("sw_008", 32'h008, 32'hCAFE_1234, 3'b010, 4'b1111, 32'hCAFE_1234, 32'h008, 5'd2);

    // Load acked three cycles after the request.
    set_ex(32'h40, 32'd0, 3'b010, 1'b1, 1'b0, 5'd7, 1'b1);
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0BAD_0BAD;
    sb.push_back('{32'h40, 32'hDEAD_BEEF, 1'b1, 1'b1, 5'd7});
    holdcnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (mem_hold) holdcnt++;
      if (i == 1) chk("lw3_wb_held", 32'(MEM_WB_rd), 32'd2);
      tick();
    end
    dmem_ack = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    if (mem_hold) holdcnt++;
    tick();
    check_wb("lw3");
    chk("lw3_holdcycles", 32'(holdcnt), 32'd3);
    idle_ex();

    // No ack: abandoned after four WAIT cycles.
    set_ex(32'h80, 32'd0, 3'b010, 1'b1, 1'b0, 5'd9, 1'b1);
    dmem_rdata = 32'd0;
    sb.push_back('{32'h80, 32'd0, 1'b1, 1'b0, 5'd9});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("to_hold", 32'(mem_hold), 32'd1);
      chk("to_err_early", 32'(mem_err), 32'd0);
      tick();
    end
    @(negedge clk);
    chk("to_lastreq", 32'(dmem_req), 32'd1);
    chk("to_lasthold", 32'(mem_hold), 32'd0);
    tick();
    chk("to_err", 32'(mem_err), 32'd1);
    check_wb("to");
    idle_ex();
    tick();
    chk("to_err_pulse", 32'(mem_err), 32'd0);
    chk("to_idle_req", 32'(dmem_req), 32'd0);

    // Debug freeze across an ack parks the data in DONE.
    set_ex(32'h10, 32'd0, 3'b010, 1'b1, 1'b0, 5'd3, 1'b1);
    dmem_ack = 1'b0;
    sb.push_back('{32'h10, 32'hCAFE_F00D, 1'b1, 1'b1, 5'd3});
    tick();
    dbg = 1'b1;
    dmem_ack = 1'b1;
    dmem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("dbg_ackhold", 32'(mem_hold), 32'd0);
    tick();
    dmem_ack = 1'b0;
    dmem_rdata = 32'h1111_1111;
    @(negedge clk);
    chk("dbg_donehold", 32'(mem_hold), 32'd1);
    chk("dbg_wb_held", 32'(MEM_WB_rd), 32'd9);
    tick();
    dbg = 1'b0;
    @(negedge clk);
    chk("dbg_release_hold", 32'(mem_hold), 32'd0);
    chk("dbg_release_req", 32'(dmem_req), 32'd0);
    tick();
    check_wb("dbg");
    idle_ex();

    // Non-memory op passes through in one cycle.
    set_ex(32'h55AA, 32'd0, 3'b000, 1'b0, 1'b0, 5'd12, 1'b1);
    EX_MEM_mul_ready = 1'b1;
    EX_MEM_mulres = 32'h1234_5678;
    EX_MEM_div_ready = 1'b1;
    EX_MEM_divres = 32'h9ABC_DEF0;
    dmem_rdata = 32'd0;
    sb.push_back('{32'h55AA, 32'd0, 1'b0, 1'b1, 5'd12});
    @(negedge clk);
    chk("alu_req", 32'(dmem_req), 32'd0);
    tick();
    check_wb("alu");
    chk("alu_mulres", MEM_WB_mulres, 32'h1234_5678);
    chk("alu_divres", MEM_WB_divres, 32'h9ABC_DEF0);
    chk("alu_mulrdy", 32'(MEM_WB_mul_ready), 32'd1);
    chk("alu_divrdy", 32'(MEM_WB_div_ready), 32'd1);

    zload("lhu_106", 32'h106, 3'b101, 32'h8001_7FFF, 32'h0000_8001, 5'd13);
    zload("lh_104", 32'h104, 3'b001, 32'h8001_7FFF, 32'h0000_7FFF, 5'd14);
    zload("lh_106", 32'h106, 3'b001, 32'h8001_7FFF, 32'hFFFF_8001, 5'd15);
    zload("lbu_101", 32'h101, 3'b100, 32'h0000_F000, 32'h0000_00F0, 5'd16);
    zload("f3_111", 32'h104, 3'b111, 32'h8765_4321, 32'h8765_4321, 5'd17);

`ifdef MEM_MISALIGN_TRAP_EN
    set_ex(32'h101, 32'd0, 3'b010, 1'b1, 1'b0, 5'd6, 1'b1);
    dmem_ack = 1'b0;
    dmem_rdata = 32'h1122_3344;
    sb.push_back('{32'h101, 32'h1122_3344, 1'b1, 1'b0, 5'd6});
    @(negedge clk);
    chk("mis_req", 32'(dmem_req), 32'd0);
    chk("mis_hold", 32'(mem_hold), 32'd0);
    tick();
    check_wb("mis");
    chk("mis_pulse", 32'(mem_misalign), 32'd1);
    idle_ex();
    tick();
    chk("mis_pulse_end", 32'(mem_misalign), 32'd0);
`else
    set_ex(32'h101, 32'd0, 3'b010, 1'b1, 1'b0, 5'd6, 1'b1);
    dmem_ack = 1'b1;
    dmem_rdata = 32'h1122_3344;
    sb.push_back('{32'h101, 32'h1122_3344, 1'b1, 1'b1, 5'd6});
    @(negedge clk);
    chk("mis_req", 32'(dmem_req), 32'd1);
    chk("mis_addr", dmem_addr, 32'h100);
    tick();
    check_wb("mis");
    chk("mis_off", 32'(mem_misalign), 32'd0);
    idle_ex();
`endif

    // Asynchronous reset in the middle of a waiting access.
    zload("pre_rst", 32'h20, 3'b010, 32'h0000_0042, 32'h0000_0042, 5'd20);
    set_ex(32'h300, 32'd0, 3'b010, 1'b1, 1'b0, 5'd4, 1'b1);
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("mid_req", 32'(dmem_req), 32'd1);
    tick();
    #2;
    Rst = 1'b1;
    #1;
    chk("midrst_req", 32'(dmem_req), 32'd0);
    chk("midrst_hold", 32'(mem_hold), 32'd0);
    chk("midrst_regwrite", 32'(MEM_WB_regwrite), 32'd0);
    chk("midrst_rd", 32'(MEM_WB_rd), 32'd0);
    chk("midrst_memres", MEM_WB_memres, 32'd0);
    idle_ex();
    tick();
    Rst = 1'b0;
    tick();
    chk("post_rst_req", 32'(dmem_req), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
